// File: rtl/mux4_sel_if.sv
// ---------------------------------------------------------------------------
// mux4_sel_if
//   Bundle of the data/select/enable signals of a 4:1 selector together with
//   its combinational and registered results.
//
//   master : the block that supplies sel, en and the four sources and
//            consumes the results (a testbench or an upstream steering block).
//   slave  : the selector itself.
//
//   Signals
//     en     load enable for the registered copy
//     sel    2-bit source select (00=in0, 01=in1, 10=in2, 11=in3)
//     in0-3  WIDTH-bit data sources
//     out    combinational in[sel]
//     out_q  registered copy of out
//     sel_q  select value captured together with out_q
// ---------------------------------------------------------------------------
interface mux4_sel_if #(
    parameter int WIDTH = 1
);
    logic             en;
    logic [1:0]       sel;
    logic [WIDTH-1:0] in0;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic [WIDTH-1:0] in3;
    logic [WIDTH-1:0] out;
    logic [WIDTH-1:0] out_q;
    logic [1:0]       sel_q;

    modport master (
        output en, sel, in0, in1, in2, in3,
        input  out, out_q, sel_q
    );

    modport slave (
        input  en, sel, in0, in1, in2, in3,
        output out, out_q, sel_q
    );
endinterface

// File: rtl/mux4_sel.sv
// ---------------------------------------------------------------------------
// mux4_sel
//   4:1 selector with a zero-latency combinational output and a registered
//   copy of the same result for timing-critical consumers.
//
//   Parameters
//     WIDTH      bit width of each source and of both results
//     RESET_VAL  value held in out_q while rst is asserted
//
//   Ports
//     clk        rising-edge clock for the registered path
//     rst        asynchronous, active-high reset of the registered path
//     bus        mux4_sel_if slave modport: en, sel, in0..in3 in;
//                out, out_q, sel_q out
//
//   Handshake: there is no valid/ready flow control. out follows sel and the
//   sources continuously; out_q/sel_q load on every rising clk edge where
//   en=1 and rst=0, and hold otherwise.
// ---------------------------------------------------------------------------
module mux4_sel #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input logic        clk,
    input logic        rst,
    mux4_sel_if.slave  bus
);

    logic [WIDTH-1:0] mux_out;

    // Flat case decode: the four codes are mutually exclusive, so there is no
    // priority chain. A non-binary sel (X/Z in simulation) matches none of the
    // explicit codes and lands in the default, forcing all zeros instead of
    // letting X reach the output.
    always_comb begin
        mux_out = '0;
        case (bus.sel)
            2'b00:   mux_out = bus.in0;
            2'b01:   mux_out = bus.in1;
            2'b10:   mux_out = bus.in2;
            2'b11:   mux_out = bus.in3;
            default: mux_out = '0;
        endcase
    end

    assign bus.out = mux_out;

    // Registered copy. It loads the same mux result that drives out, so a
    // simultaneous sel and data change is captured as one coherent value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out_q <= RESET_VAL;
            bus.sel_q <= 2'b00;
        end else if (bus.en) begin
            bus.out_q <= mux_out;
            bus.sel_q <= bus.sel;
        end
    end

endmodule

// File: tb/tb_mux4_sel.sv
// ---------------------------------------------------------------------------
// tb_mux4_sel
//   Two selector instances share clk/rst: a 1-bit one with RESET_VAL=0 and an
//   8-bit one with RESET_VAL=8'h5A. Inputs change on the falling edge, the
//   combinational output is checked 1 ns later, and the registered outputs
//   1 ns after the rising edge. The reference model keeps each instance's
//   sources in an array and picks src[sel]; registered state is tracked as
//   "last value picked while enabled and out of reset".
// ---------------------------------------------------------------------------
module tb_mux4_sel;

    logic clk;
    logic rst;

    mux4_sel_if #(.WIDTH(1)) b1 ();
    mux4_sel_if #(.WIDTH(8)) b8 ();

    mux4_sel #(.WIDTH(1), .RESET_VAL(1'b0)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (b1.slave)
    );

    mux4_sel #(.WIDTH(8), .RESET_VAL(8'h5A)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (b8.slave)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- model and counters ----------------
    int         checks = 0;
    int         errors = 0;
    logic       m1_q;
    logic [1:0] m1_sel;
    logic [7:0] m8_q;
    logic [1:0] m8_sel;
    logic [7:0] exp_q[$];

    function automatic logic pick1(input logic [1:0] s);
        logic src[4];
        src = '{b1.in0, b1.in1, b1.in2, b1.in3};
        return src[s];
    endfunction

    function automatic logic [7:0] pick8(input logic [1:0] s);
        logic [7:0] src[4];
        src = '{b8.in0, b8.in1, b8.in2, b8.in3};
        return src[s];
    endfunction

    // Advance one rising edge and update the model from the pre-edge inputs.
    task automatic tick();
        logic       e1, e8;
        logic       n1;
        logic [7:0] n8;
        logic [1:0] s1, s8;
        e1 = b1.en;  s1 = b1.sel;  n1 = pick1(b1.sel);
        e8 = b8.en;  s8 = b8.sel;  n8 = pick8(b8.sel);
        @(posedge clk);
        #1;
        if (rst) begin
            m1_q = 1'b0;  m1_sel = 2'b00;
            m8_q = 8'h5A; m8_sel = 2'b00;
        end else begin
            if (e1) begin m1_q = n1; m1_sel = s1; end
            if (e8) begin m8_q = n8; m8_sel = s8; end
        end
    endtask

    task automatic set1(input logic [1:0] s, input logic [3:0] d);
        b1.sel = s;
        b1.in0 = d[0]; b1.in1 = d[1]; b1.in2 = d[2]; b1.in3 = d[3];
    endtask

    task automatic set8(input logic [1:0] s, input logic [7:0] d0, input logic [7:0] d1,
                        input logic [7:0] d2, input logic [7:0] d3);
        b8.sel = s;
        b8.in0 = d0; b8.in1 = d1; b8.in2 = d2; b8.in3 = d3;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        b1.en = 1'b1; b8.en = 1'b1;
        set1(2'b01, 4'b1111);
        set8(2'b10, 8'h11, 8'h22, 8'h33, 8'h44);
        #2;
        checks++;
        if (b1.out_q !== 1'b0 || b1.sel_q !== 2'b00) begin
            errors++;
            $display("FAIL reset_w1: out_q=%b sel_q=%b expected out_q=0 sel_q=00", b1.out_q, b1.sel_q);
        end
        checks++;
        if (b8.out_q !== 8'h5A || b8.sel_q !== 2'b00) begin
            errors++;
            $display("FAIL reset_w8: out_q=%h sel_q=%b expected out_q=5a sel_q=00", b8.out_q, b8.sel_q);
        end
        // A rising edge with en=1 while in reset must not load.
        tick();
        checks++;
        if (b1.out_q !== 1'b0 || b8.out_q !== 8'h5A || b8.sel_q !== 2'b00) begin
            errors++;
            $display("FAIL reset_hold_edge: w1 out_q=%b w8 out_q=%h sel_q=%b expected 0/5a/00",
                     b1.out_q, b8.out_q, b8.sel_q);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_w1_basic();
        logic [1:0] sels[8];
        logic [3:0] data[8];
        logic       expv[8];
        sels = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b01, 2'b11, 2'b10};
        data = '{4'b1010, 4'b1010, 4'b1100, 4'b1100, 4'b1100, 4'b1100, 4'b0111, 4'b1011};
        expv = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            b1.en = 1'b1;
            set1(sels[i], data[i]);
            #1;
            checks++;
            if (b1.out !== expv[i]) begin
                errors++;
                $display("FAIL w1_out[%0d]: out=%b expected %b", i, b1.out, expv[i]);
            end
            tick();
            checks++;
            if (b1.out_q !== expv[i] || b1.sel_q !== sels[i]) begin
                errors++;
                $display("FAIL w1_outq[%0d]: out_q=%b sel_q=%b expected %b %b",
                         i, b1.out_q, b1.sel_q, expv[i], sels[i]);
            end
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        b1.en = 1'b1; b8.en = 1'b1;
        set1(2'b01, 4'b1010);
        set8(2'b11, 8'h01, 8'h02, 8'h03, 8'hC3);
        tick();
        checks++;
        if (b1.out_q !== 1'b1 || b8.out_q !== 8'hC3) begin
            errors++;
            $display("FAIL pre_async: w1 out_q=%b w8 out_q=%h expected 1 c3", b1.out_q, b8.out_q);
        end
        // Assert mid-cycle, well away from any rising edge.
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        checks++;
        if (b1.out_q !== 1'b0 || b1.sel_q !== 2'b00 || b8.out_q !== 8'h5A || b8.sel_q !== 2'b00) begin
            errors++;
            $display("FAIL async_reset: w1 %b/%b w8 %h/%b expected 0/00 5a/00",
                     b1.out_q, b1.sel_q, b8.out_q, b8.sel_q);
        end
        m1_q = 1'b0; m1_sel = 2'b00; m8_q = 8'h5A; m8_sel = 2'b00;
        @(negedge clk);
        rst = 1'b0;
        b1.en = 1'b1;
        set1(2'b11, 4'b1000);
        tick();
        checks++;
        if (b1.out_q !== 1'b1 || b1.sel_q !== 2'b11) begin
            errors++;
            $display("FAIL first_load: out_q=%b sel_q=%b expected 1 11", b1.out_q, b1.sel_q);
        end
    endtask

    task automatic test_hold();
        @(negedge clk);
        b8.en = 1'b1;
        set8(2'b10, 8'h10, 8'h20, 8'h7E, 8'h40);
        tick();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            b8.en = 1'b0; b1.en = 1'b0;
            set8(2'(i), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
            set1(2'(i), 4'($urandom));
            #1;
            checks++;
            if (b8.out !== pick8(2'(i)) || b1.out !== pick1(2'(i))) begin
                errors++;
                $display("FAIL hold_out[%0d]: w8 out=%h w1 out=%b expected %h %b",
                         i, b8.out, b1.out, pick8(2'(i)), pick1(2'(i)));
            end
            tick();
            checks++;
            if (b8.out_q !== 8'h7E || b8.sel_q !== 2'b10 || b1.out_q !== 1'b1 || b1.sel_q !== 2'b11) begin
                errors++;
                $display("FAIL hold_q[%0d]: w8 %h/%b w1 %b/%b expected 7e/10 1/11",
                         i, b8.out_q, b8.sel_q, b1.out_q, b1.sel_q);
            end
        end
    endtask

    task automatic test_sweep8();
        logic [7:0] tbl[4];
        logic [7:0] e;
        tbl = '{8'hA5, 8'h3C, 8'hFF, 8'h00};
        for (int s = 0; s < 4; s++) begin
            @(negedge clk);
            b8.en = 1'b1;
            set8(2'(s), 8'hA5, 8'h3C, 8'hFF, 8'h00);
            #1;
            checks++;
            if (b8.out !== tbl[s]) begin
                errors++;
                $display("FAIL sweep_out[%0d]: out=%h expected %h", s, b8.out, tbl[s]);
            end
            exp_q.push_back(tbl[s]);
            tick();
            e = exp_q.pop_front();
            checks++;
            if (b8.out_q !== e || b8.sel_q !== 2'(s)) begin
                errors++;
                $display("FAIL sweep_outq[%0d]: out_q=%h sel_q=%b expected %h %b",
                         s, b8.out_q, b8.sel_q, e, 2'(s));
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            b1.en = 1'($urandom_range(0, 1));
            b8.en = 1'($urandom_range(0, 1));
            set1(2'($urandom_range(0, 3)), 4'($urandom));
            set8(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
            #1;
            checks++;
            if (b1.out !== pick1(b1.sel) || b8.out !== pick8(b8.sel)) begin
                errors++;
                $display("FAIL rand_out[%0d]: w1 %b w8 %h expected %b %h",
                         i, b1.out, b8.out, pick1(b1.sel), pick8(b8.sel));
            end
            tick();
            checks++;
            if (b1.out_q !== m1_q || b1.sel_q !== m1_sel || b8.out_q !== m8_q || b8.sel_q !== m8_sel) begin
                errors++;
                $display("FAIL rand_q[%0d]: w1 %b/%b w8 %h/%b expected %b/%b %h/%b",
                         i, b1.out_q, b1.sel_q, b8.out_q, b8.sel_q, m1_q, m1_sel, m8_q, m8_sel);
            end
        end
    endtask

    task automatic test_sel_x();
        logic [7:0] e8;
        logic       e1;
        @(negedge clk);
        b1.en = 1'b0; b8.en = 1'b0;
        set1(2'bxx, 4'b1111);
        set8(2'bxx, 8'hA5, 8'h3C, 8'hFF, 8'h81);
        #1;
        // A two-state simulator resolves the X to some binary code; a
        // four-state one keeps it unknown and the selector must give zeros.
        e1 = $isunknown(b1.sel) ? 1'b0 : pick1(b1.sel);
        e8 = $isunknown(b8.sel) ? 8'h00 : pick8(b8.sel);
        checks++;
        if ($isunknown(b1.out) || b1.out !== e1) begin
            errors++;
            $display("FAIL sel_x_w1: out=%b expected %b", b1.out, e1);
        end
        checks++;
        if ($isunknown(b8.out) || b8.out !== e8) begin
            errors++;
            $display("FAIL sel_x_w8: out=%h expected %h", b8.out, e8);
        end
        set1(2'b00, 4'b0000);
        set8(2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
        tick();
    endtask

    // ---------------- sequence ----------------
    initial begin
        m1_q = 1'b0; m1_sel = 2'b00; m8_q = 8'h5A; m8_sel = 2'b00;
        test_reset();
        test_w1_basic();
        test_async_reset();
        test_hold();
        test_sweep8();
        test_random();
        test_sel_x();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
